// File: rtl/ir_nec_decoder.sv
// NEC IR remote decoder: microsecond-timed pulse classifier and LSB-first frame assembler.
// Define IR_CHECKSUM_EN to reject frames whose command byte fails its inverted copy.
module ir_nec_decoder #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TIMEOUT_US  = 12000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ir_rx,
    output logic [31:0] ir_command,
    output logic        ir_data_ready,
    output logic        ir_repeat,
    output logic        ir_frame_error,
    output logic        busy
);
    localparam int DIV = CLK_FREQ_HZ / 1_000_000;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEADER_MARK,
        LEADER_SPACE,
        BIT_MARK,
        BIT_SPACE,
        REPEAT_MARK
    } state_t;

    state_t        state, state_n;
    logic          s1, s2, s3;
    logic          fall, rise, any_edge;
    logic [PW-1:0] presc;
    logic [13:0]   dur, dur_eff;
    logic          wrap;
    logic [31:0]   shreg, shreg_n;
    logic [5:0]    bit_cnt, cnt_n;
    logic          frame_seen;
    logic          done, rep, accept, reject;

    function automatic logic in_win(input logic [13:0] d, input int lo, input int hi);
        return (int'(d) >= lo) && (int'(d) <= hi);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= ir_rx;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign fall     = s3 & ~s2;
    assign rise     = ~s3 & s2;
    assign any_edge = fall | rise;
    assign wrap     = (presc == PMAX);

    // Length of the level that ends this cycle, counting the current tick
    assign dur_eff = (wrap && dur != 14'h3FFF) ? dur + 14'd1 : dur;

    always_ff @(posedge clk) begin
        if (reset || any_edge) begin
            presc <= '0;
            dur   <= '0;
        end else if (wrap) begin
            presc <= '0;
            if (dur != 14'h3FFF) dur <= dur + 14'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = bit_cnt;
        done    = 1'b0;
        rep     = 1'b0;
        unique case (state)
            IDLE: if (fall) state_n = LEADER_MARK;
            LEADER_MARK: if (rise) begin
                state_n = in_win(dur_eff, 8000, 10000) ? LEADER_SPACE : IDLE;
            end
            LEADER_SPACE: if (fall) begin
                if (in_win(dur_eff, 4000, 5000)) begin
                    cnt_n   = '0;
                    state_n = BIT_MARK;
                end else if (in_win(dur_eff, 2000, 2500)) begin
                    state_n = REPEAT_MARK;
                end else begin
                    state_n = LEADER_MARK;
                end
            end
            BIT_MARK: if (rise) begin
                if (!in_win(dur_eff, 400, 700)) begin
                    state_n = IDLE;
                end else if (bit_cnt == 6'd32) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end else begin
                    state_n = BIT_SPACE;
                end
            end
            BIT_SPACE: if (fall) begin
                if (in_win(dur_eff, 400, 700) || in_win(dur_eff, 1400, 1900)) begin
                    shreg_n = {in_win(dur_eff, 1400, 1900), shreg[31:1]};
                    cnt_n   = bit_cnt + 6'd1;
                    state_n = BIT_MARK;
                end else begin
                    state_n = LEADER_MARK;
                end
            end
            REPEAT_MARK: if (rise) begin
                rep     = in_win(dur_eff, 400, 700) & frame_seen;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // A stuck level abandons the frame; an edge this cycle takes priority
        if (state != IDLE && !any_edge && int'(dur) >= TIMEOUT_US) state_n = IDLE;
    end

`ifdef IR_CHECKSUM_EN
    logic chk_ok;
    assign chk_ok = (shreg[31:24] == ~shreg[23:16]);
    assign accept = done & chk_ok;
    assign reject = done & ~chk_ok;

    always_ff @(posedge clk) begin
        if (reset) ir_frame_error <= 1'b0;
        else       ir_frame_error <= reject;
    end
`else
    assign accept = done;
    assign reject = 1'b0;
    assign ir_frame_error = reject;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            shreg         <= '0;
            bit_cnt       <= '0;
            frame_seen    <= 1'b0;
            ir_command    <= '0;
            ir_data_ready <= 1'b0;
            ir_repeat     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            shreg         <= shreg_n;
            bit_cnt       <= cnt_n;
            ir_data_ready <= accept;
            ir_repeat     <= rep;
            busy          <= (state_n != IDLE);
            if (accept) begin
                ir_command <= shreg;
                frame_seen <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ir_nec_decoder.sv
// Directed-plus-random bench for ir_nec_decoder at 1 clock per microsecond.
// Expected outputs come from a frame-level model of the NEC rules.
module tb_ir_nec_decoder;
    logic        clk = 1'b0;
    logic        reset;
    logic        ir_rx;
    logic [31:0] ir_command;
    logic        ir_data_ready;
    logic        ir_repeat;
    logic        ir_frame_error;
    logic        busy;

    int total = 0;
    int bad = 0;
    int n_rdy = 0, n_rep = 0, n_err = 0;
    int e_rdy = 0, e_rep = 0, e_err = 0;
    logic [31:0] e_cmd = '0;
    bit e_seen = 0;

    ir_nec_decoder #(
        .CLK_FREQ_HZ(1_000_000),
        .TIMEOUT_US (12000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ir_rx         (ir_rx),
        .ir_command    (ir_command),
        .ir_data_ready (ir_data_ready),
        .ir_repeat     (ir_repeat),
        .ir_frame_error(ir_frame_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ir_data_ready) n_rdy++;
        if (ir_repeat) n_rep++;
        if (ir_frame_error) n_err++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mark(input int us);
        ir_rx = 1'b0;
        repeat (us) @(negedge clk);
    endtask

    task automatic space(input int us);
        ir_rx = 1'b1;
        repeat (us) @(negedge clk);
    endtask

    function automatic bit accepts(input logic [31:0] w);
`ifdef IR_CHECKSUM_EN
        return w[31:24] == ~w[23:16];
`else
        return 1'b1;
`endif
    endfunction

    // Leader + header + n bits, each bit a mark and its space.
    task automatic head_bits(input logic [31:0] w, input int n,
                             input int lead, input bit jit);
        mark(lead);
        space(4500);
        for (int i = 0; i < n; i++) begin
            mark(jit ? int'($urandom_range(400, 700)) : 560);
            if (w[i]) space(jit ? int'($urandom_range(1400, 1900)) : 1690);
            else      space(jit ? int'($urandom_range(400, 700)) : 560);
        end
    endtask

    // Full frame ending with the stop-mark rise; the line is left high.
    task automatic frame(input logic [31:0] w, input int lead, input bit jit);
        head_bits(w, 32, lead, jit);
        mark(560);
        ir_rx = 1'b1;
        if (accepts(w)) begin
            e_cmd  = w;
            e_seen = 1;
            e_rdy++;
        end else begin
            e_err++;
        end
    endtask

    task automatic rep_code();
        mark(9000);
        space(2250);
        mark(560);
        ir_rx = 1'b1;
        if (e_seen) e_rep++;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_rdy"}, n_rdy, e_rdy);
        chk({tag, "_rep"}, n_rep, e_rep);
        chk({tag, "_err"}, n_err, e_err);
        chk({tag, "_cmd"}, ir_command, e_cmd);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [31:0] w;
        ir_rx = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cmd", ir_command, 32'h0);
        chk("rst_rdy", ir_data_ready, 1'b0);
        chk("rst_rep", ir_repeat, 1'b0);
        chk("rst_err", ir_frame_error, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        space(20);

        rep_code();
        space(50);
        chk_all("rep_after_rst");

        frame(32'hED126B86, 9000, 0);
        @(negedge clk);
        chk("lat1_rdy", ir_data_ready, 1'b0);
        @(negedge clk);
        chk("lat2_rdy", ir_data_ready, 1'b0);
        chk("lat2_busy", busy, 1'b1);
        @(negedge clk);
        chk("lat3_rdy", ir_data_ready, 1'b1);
        chk("lat3_busy", busy, 1'b0);
        chk("lat3_cmd", ir_command, 32'hED126B86);
        @(negedge clk);
        chk("lat4_rdy", ir_data_ready, 1'b0);
        space(50);
        chk_all("power");

        rep_code();
        space(50);
        chk_all("repeat");

        frame(32'hED136B86, 9000, 0);
        space(50);
        chk_all("bad_csum");

        mark(7900);
        space(10);
        chk("lead7900_busy", busy, 1'b0);
        space(40);
        chk_all("lead7900");

        head_bits(32'h5, 3, 9000, 0);
        mark(560);
        space(1350);
        mark(5);
        chk("abort_busy", busy, 1'b1);
        mark(555);
        space(50);
        chk_all("abort1350");

        head_bits($urandom, 16, 9000, 1);
        mark(560);
        space(11900);
        chk("tmo_busy_hi", busy, 1'b1);
        space(3100);
        chk_all("timeout");

        frame(32'hE9166B86, 9000, 0);
        space(50);
        chk_all("play");

        head_bits($urandom, 20, 9000, 1);
        mark(200);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_cmd", ir_command, 32'h0);
        e_cmd  = '0;
        e_seen = 0;
        mark(300);
        space(50);
        chk_all("midrst");

        w = $urandom;
        w[23:16] = ~w[31:24];
        frame(w, 8000, 1);
        space(50);
        chk_all("rand_frame");

        rep_code();
        space(50);
        chk_all("rand_repeat");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
